load_store_unit: RTL and testbench

- Data-memory access stage between the multicycle control unit (MEM state) and the data-memory bus.
- Latches address, store data and access size when the control unit raises dmem_rd or dmem_we.
- Runs a req/ack bus transaction, then aligns, sign- or zero-extends and returns load data.
- The control unit stays in MEM while busy=1 and leaves MEM on done or fault.

---
 rtl/load_store_unit_pkg.sv | 12 +
 rtl/load_store_unit_load_align.sv | 17 +
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: load funct3 codes, store size masks and LSU state encodings.
package load_store_unit_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} lsu_state_e;
endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: shifts the captured bus word down to the addressed lane and extends it.
module load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);
    logic [31:0] sh;
    assign sh = word_i >> {off_i, 3'b000};
    always_comb
        data_o = funct3_i == F3_LB  ? {{24{sh[7]}}, sh[7:0]}   :
                 funct3_i == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
                 funct3_i == F3_LBU ? {24'b0, sh[7:0]}         :
                 funct3_i == F3_LHU ? {16'b0, sh[15:0]}        : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: latches a load/store request, runs one req/ack bus transaction
// with timeout, and returns aligned, extended load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmem_rd,
    input  logic [3:0]            dmem_we,
    input  logic [2:0]            load_select,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic                  bus_req,
    output logic [3:0]            bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] sd_q, sd_d, load_q, load_d, aligned;
    logic [3:0]            mask_q, mask_d;
    logic [2:0]            sel_q, sel_d;
    logic                  store_q, store_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  start, is_st, half, word, illegal;

    assign is_st = |dmem_we;
    assign start = (dmem_rd | is_st) && state_q == S_IDLE;
    assign half  = is_st ? dmem_we == MASK_H : load_select[1:0] == 2'b01;
    assign word  = is_st ? dmem_we == MASK_W : load_select[1:0] == 2'b10;
    assign illegal = (half && addr[0]) || (word && addr[1:0] != 2'b00) ||
                     (!is_st && (load_select == 3'b011 || load_select[2:1] == 2'b11)) ||
                     (is_st && !(dmem_we inside {MASK_B, MASK_H, MASK_W}));

    load_align u_align (
        .word_i   (bus_rdata),
        .off_i    (addr_q[1:0]),
        .funct3_i (sel_q),
        .data_o   (aligned)
    );

    assign addr_d  = start ? addr : addr_q;
    assign sd_d    = start ? store_data : sd_q;
    assign mask_d  = start ? dmem_we : mask_q;
    assign sel_d   = start ? load_select : sel_q;
    assign store_d = start ? is_st : store_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = illegal ? S_FAULT : S_REQ;
                cnt_d   = '0;
            end
            S_REQ: if (bus_ack) begin
                state_d = S_DONE;
                load_d  = store_q ? load_q : aligned;
            end else if (cnt_q == TMO) begin
                state_d = S_FAULT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            sd_q    <= '0;
            mask_q  <= '0;
            sel_q   <= '0;
            store_q <= 1'b0;
            cnt_q   <= '0;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sd_q    <= sd_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            store_q <= store_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign fault     = state_q == S_FAULT;
    assign bus_req   = state_q == S_REQ;
    assign bus_we    = (bus_req && store_q) ? mask_q << addr_q[1:0] : 4'b0000;
    assign bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign bus_wdata = mask_q == MASK_B ? {4{sd_q[7:0]}}  :
                       mask_q == MASK_H ? {2{sd_q[15:0]}} : sd_q;
    assign load_data = load_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors with hand-computed expectations.
module tb_load_store_unit;
    logic        clk = 0, rst = 1;
    logic        dmem_rd = 0, bus_ack = 0;
    logic [3:0]  dmem_we = 0;
    logic [2:0]  load_select = 0;
    logic [31:0] addr = 0, store_data = 0, bus_rdata = 0;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_we;
    logic        busy, done, fault, bus_req;
    int n_chk = 0, n_err = 0;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .dmem_rd(dmem_rd), .dmem_we(dmem_we),
        .load_select(load_select), .addr(addr), .store_data(store_data),
        .load_data(load_data), .busy(busy), .done(done), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request, acks after `waits` REQ cycles (never if waits<0) and
    // reports the cycle of done/fault relative to the start edge.
    task automatic xact(input logic rd, input logic [3:0] we, input logic [2:0] sel,
                        input logic [31:0] a, input logic [31:0] sd, input int waits,
                        input logic [31:0] rdata, output int cyc, output int nreq,
                        output logic [31:0] b_addr, output logic [3:0] b_we,
                        output logic [31:0] b_wd, output logic f);
        @(negedge clk);
        dmem_rd = rd; dmem_we = we; load_select = sel; addr = a; store_data = sd;
        @(negedge clk);
        dmem_rd = 0; dmem_we = 0;
        cyc = -1; nreq = 0; f = 0; b_addr = 0; b_we = 0; b_wd = 0;
        for (int c = 1; c < 30; c++) begin
            if (done || fault) begin
                cyc = c; f = fault;
                break;
            end
            if (bus_req && nreq == 0) begin
                b_addr = bus_addr; b_we = bus_we; b_wd = bus_wdata;
            end
            bus_ack = bus_req && nreq == waits;
            bus_rdata = rdata;
            if (bus_req) nreq++;
            @(negedge clk);
            bus_ack = 0;
        end
    endtask

    int cyc, nreq;
    logic [31:0] ba, bw;
    logic [3:0] bwe;
    logic f, bad;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_we", bus_we, 0);
        chk("rst_load", load_data, 0);
        chk("rst_flags", {done, fault}, 0);
        rst = 0;

        xact(0, 4'b1111, 3'b000, 32'h1004, 32'hDEADBEEF, 0, 0, cyc, nreq, ba, bwe, bw, f);
        chk("sw_cyc", cyc, 2);
        chk("sw_addr", ba, 32'h1004);
        chk("sw_we", bwe, 4'b1111);
        chk("sw_wd", bw, 32'hDEADBEEF);
        chk("sw_fault", f, 0);
        @(negedge clk);
        chk("sw_after", {done, busy}, 0);

        xact(0, 4'b0001, 3'b000, 32'h2003, 32'h000000A5, 0, 0, cyc, nreq, ba, bwe, bw, f);
        chk("sb_cyc", cyc, 2);
        chk("sb_addr", ba, 32'h2000);
        chk("sb_we", bwe, 4'b1000);
        chk("sb_wd", bw, 32'hA5A5A5A5);

        xact(1, 4'b0000, 3'b000, 32'h3001, 0, 3, 32'h00008000, cyc, nreq, ba, bwe, bw, f);
        chk("lb_cyc", cyc, 5);
        chk("lb_data", load_data, 32'hFFFFFF80);
        chk("lb_we", bwe, 0);
        chk("lb_addr", ba, 32'h3000);

        xact(1, 4'b0000, 3'b100, 32'h3001, 0, 0, 32'h00008000, cyc, nreq, ba, bwe, bw, f);
        chk("lbu_data", load_data, 32'h00000080);

        xact(1, 4'b0000, 3'b001, 32'h3002, 0, 1, 32'h80000000, cyc, nreq, ba, bwe, bw, f);
        chk("lh_cyc", cyc, 3);
        chk("lh_data", load_data, 32'hFFFF8000);

        xact(1, 4'b0000, 3'b010, 32'h3002, 0, 0, 32'h12345678, cyc, nreq, ba, bwe, bw, f);
        chk("lw_mis_fault", f, 1);
        chk("lw_mis_cyc", cyc, 1);
        chk("lw_mis_req", nreq, 0);
        chk("lw_mis_data", load_data, 32'hFFFF8000);

        xact(0, 4'b0101, 3'b000, 32'h3000, 0, 0, 0, cyc, nreq, ba, bwe, bw, f);
        chk("bad_mask", {f, 8'(nreq)}, {1'b1, 8'd0});

        xact(1, 4'b0000, 3'b111, 32'h3000, 0, 0, 0, cyc, nreq, ba, bwe, bw, f);
        chk("bad_f3", {f, 8'(nreq)}, {1'b1, 8'd0});

        xact(1, 4'b0000, 3'b010, 32'h7000, 0, -1, 0, cyc, nreq, ba, bwe, bw, f);
        chk("tmo_req", nreq, 5);
        chk("tmo_fault", f, 1);
        chk("tmo_cyc", cyc, 6);
        chk("tmo_data", load_data, 32'hFFFF8000);

        xact(0, 4'b0011, 3'b000, 32'h4002, 32'h00001234, 0, 0, cyc, nreq, ba, bwe, bw, f);
        chk("sh_cyc", cyc, 2);
        chk("sh_we", bwe, 4'b1100);
        chk("sh_wd", bw, 32'h12341234);

        xact(1, 4'b1111, 3'b010, 32'h5000, 32'h11223344, 0, 32'hFFFFFFFF, cyc, nreq, ba, bwe, bw, f);
        chk("both_we", bwe, 4'b1111);
        chk("both_wd", bw, 32'h11223344);
        chk("both_data", load_data, 32'hFFFF8000);

        @(negedge clk);
        dmem_rd = 1; load_select = 3'b010; addr = 32'h6000;
        @(negedge clk);
        dmem_rd = 0;
        chk("rst_mid_req", bus_req, 1);
        rst = 1;
        #1;
        chk("rst_async_req", bus_req, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_load", load_data, 0);
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            bad = bad | done | fault | busy;
        end
        chk("rst_no_pulse", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
